// File: rtl/fp_pkg.sv
// fp_pkg: shared widths, FSM encoding and operand classifiers
// for the iterative floating-point multiplier.
package fp_pkg;

    localparam int DEF_EXP_W = 8;
    localparam int DEF_MAN_W = 23;
    localparam int DEF_W     = 1 + DEF_EXP_W + DEF_MAN_W;
    localparam int DEF_BIAS  = (1 << (DEF_EXP_W - 1)) - 1;

    localparam logic [DEF_W-1:0] QNAN =
        {1'b0, {DEF_EXP_W{1'b1}}, 1'b1, {(DEF_MAN_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        NORM,
        DONE
    } state_t;

    function automatic logic is_nan(input logic exp_ones,
                                    input logic frac_nz);
        return exp_ones & frac_nz;
    endfunction

    function automatic logic is_inf(input logic exp_ones,
                                    input logic frac_nz);
        return exp_ones & ~frac_nz;
    endfunction

    // Subnormals share the zero class: they are flushed on input.
    function automatic logic is_zero_or_sub(input logic exp_zero);
        return exp_zero;
    endfunction

endpackage

// File: rtl/fp_mul_seq_mant.sv
// mant_mul_seq: shift-and-add significand multiplier,
// one multiplier bit retired per cycle.
module mant_mul_seq #(
    parameter int N = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] ma,
    input  logic [N-1:0] mb,
    output logic         busy,
    output logic         done,
    output logic [N:0]   prod_hi
);

    localparam int CW = $clog2(N);

    logic [2*N-1:0] mcand;
    logic [2*N-1:0] acc;
    logic [N-1:0]   mplier;
    logic [CW-1:0]  cnt;
    logic           run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            cnt    <= '0;
            run    <= 1'b0;
        end else if (start) begin
            mcand  <= {{N{1'b0}}, ma};
            acc    <= '0;
            mplier <= mb;
            cnt    <= '0;
            run    <= 1'b1;
        end else if (run) begin
            if (mplier[0])
                acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (done)
                run <= 1'b0;
        end
    end

    assign busy    = run;
    assign done    = run && (cnt == CW'(N - 1));
    // Only the top N+1 product bits survive truncating normalization.
    assign prod_hi = acc[2*N-1 -: N+1];

endmodule

// File: rtl/fp_mul_seq.sv
// fp_mul_seq: iterative IEEE-754 multiplier with valid/ready
// operand and result handshakes, fixed latency per operation.
module fp_mul_seq
    import fp_pkg::*;
#(
    parameter int EXP_W = DEF_EXP_W,
    parameter int MAN_W = DEF_MAN_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result
);

    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;
    localparam int N    = MAN_W + 1;
    localparam int EW   = EXP_W + 2;

    localparam logic [W-1:0] QNAN_W =
        {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    state_t state, state_nx;

    logic         armed;
    logic         accept;
    logic         mul_start;
    logic         mul_busy;
    logic         mul_done;
    logic [N:0]   prod_hi;
    logic [W-1:0] a_q, b_q, res_nx;

    logic             sa, sb, sign, norm;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb, frac;
    logic             nan_a, nan_b, inf_a, inf_b, zs_a, zs_b;
    logic             ovf, unf;
    logic [EW-1:0]    e_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (accept)    state_nx = MUL;
            MUL:  if (mul_done)  state_nx = NORM;
            NORM:                state_nx = DONE;
            DONE: if (out_ready) state_nx = IDLE;
            default:             state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        mul_start = 1'b0;
        if (state == IDLE) in_ready  = armed;
        if (state == DONE) out_valid = 1'b1;
        if (state == MUL)  mul_start = !mul_busy && !mul_done;
    end

    assign accept = in_valid && in_ready;

    // armed holds in_ready low for the first cycle after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            result <= '0;
        end else begin
            armed <= 1'b1;
            if (accept) begin
                a_q <= a;
                b_q <= b;
            end
            if (state == NORM)
                result <= res_nx;
        end
    end

    mant_mul_seq #(.N(N)) u_mant (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .ma      ({1'b1, fa}),
        .mb      ({1'b1, fb}),
        .busy    (mul_busy),
        .done    (mul_done),
        .prod_hi (prod_hi)
    );

    assign {sa, ea, fa} = a_q;
    assign {sb, eb, fb} = b_q;

    assign nan_a = is_nan(&ea, |fa);
    assign nan_b = is_nan(&eb, |fb);
    assign inf_a = is_inf(&ea, |fa);
    assign inf_b = is_inf(&eb, |fb);
    assign zs_a  = is_zero_or_sub(~|ea);
    assign zs_b  = is_zero_or_sub(~|eb);

    assign sign  = sa ^ sb;
    assign norm  = prod_hi[N];
    assign frac  = norm ? prod_hi[N-1:1] : prod_hi[N-2:0];
    assign e_sum = EW'(ea) + EW'(eb) - EW'(BIAS) + EW'(norm);

    assign ovf = !e_sum[EW-1] &&
                 (e_sum[EW-2:0] >= (EW-1)'((1 << EXP_W) - 1));
    assign unf = e_sum[EW-1] || (e_sum == '0);

    always_comb begin
        res_nx = {sign, e_sum[EXP_W-1:0], frac};
        if (nan_a || nan_b || (inf_a && zs_b) || (inf_b && zs_a))
            res_nx = QNAN_W;
        else if (inf_a || inf_b || ovf)
            res_nx = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (zs_a || zs_b || unf)
            res_nx = {sign, {(W-1){1'b0}}};
    end

endmodule

// File: tb/tb_fp_mul_seq.sv
// tb_fp_mul_seq: directed vectors for the iterative multiplier,
// covering latency, specials, backpressure and mid-operation reset.
module tb_fp_mul_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;

    int n_pass = 0;
    int n_tot  = 0;

    fp_mul_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic run_op(input string tag, input logic [31:0] av,
                          input logic [31:0] bv, input logic [31:0] ex,
                          input bit rel);
        int cyc;
        bit rdy_seen;
        cyc = 0;
        while (!in_ready && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_ready"}, 32'(in_ready), 32'd1);
        a = av;
        b = bv;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 32'hDEADBEEF;
        b = 32'h12345678;
        cyc = 0;
        rdy_seen = 1'b0;
        while (!out_valid && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (in_ready) rdy_seen = 1'b1;
        end
        chk({tag, "_latency"}, 32'(cyc), 32'd26);
        chk({tag, "_busy"}, 32'(rdy_seen), 32'd0);
        chk({tag, "_result"}, result, ex);
        if (rel) begin
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            chk({tag, "_vld_drop"}, 32'(out_valid), 32'd0);
            chk({tag, "_rdy_back"}, 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit stale;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rdy_pre_edge", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("rdy_post_edge", 32'(in_ready), 32'd1);

        run_op("basic", 32'h3FC00000, 32'h40000000, 32'h40400000, 1);
        run_op("sign", 32'hBF800000, 32'h3F800000, 32'hBF800000, 1);
        run_op("trunc", 32'h3F800001, 32'h3F800001, 32'h3F800002, 1);
        run_op("ovf", 32'h7F000000, 32'h7F000000, 32'h7F800000, 1);
        run_op("unf", 32'h00800000, 32'h00800000, 32'h00000000, 1);
        run_op("unf_neg", 32'h80800000, 32'h00800000, 32'h80000000, 1);
        run_op("inf_x_0", 32'h7F800000, 32'h00000000, 32'h7FC00000, 1);
        run_op("nan_in", 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1);
        run_op("neg_inf", 32'hFF800000, 32'h40000000, 32'hFF800000, 1);
        run_op("subn", 32'h00000001, 32'h3F800000, 32'h00000000, 1);

        run_op("bp", 32'h3FC00000, 32'h40000000, 32'h40400000, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a = 32'h40000000;
            b = 32'h40000000;
            @(posedge clk);
            #1;
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_result", result, 32'h40400000);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_release", 32'(in_ready), 32'd1);
        run_op("b2b", 32'h40400000, 32'h40000000, 32'h40C00000, 1);

        a = 32'h3FC00000;
        b = 32'h40000000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_result", result, 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_rdy_back", 32'(in_ready), 32'd1);
        stale = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) stale = 1'b1;
        end
        chk("mid_rst_no_stale", 32'(stale), 32'd0);
        run_op("fresh", 32'h3FC00000, 32'h40000000, 32'h40400000, 1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/fp_mul_seq.md
Name: fp_mul_seq

Overview:
- Iterative IEEE-754 floating-point multiplier; the multiply-side counterpart of the division datapath.
- Mantissa product is built by shift-and-add, one multiplier bit per cycle. This mirrors the subtract-and-select recurrence of the divider array.
- Sits beside the divider behind the same valid/ready operand interface.
- Accepts one operand pair at a time. Returns a packed result after a fixed latency.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored fraction width. Hidden bit is added internally, giving a significand of MAN_W+1 bits.
- Derived, not overridable: W = 1+EXP_W+MAN_W; BIAS = 2^(EXP_W-1)-1; LAT = MAN_W+3.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands.
- a  in  W  operand A, packed {sign, exp, frac}.
- b  in  W  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  W  packed product.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - While rst_n=0: in_ready=0, out_valid=0, result=0, FSM=IDLE, counter=0, accumulator=0.
  - in_ready rises on the first clk edge after release.
  - Reset mid-operation discards the operation with no output.
- FSM states: IDLE → MUL → NORM → DONE → IDLE.
  - IDLE: in_ready=1. On in_valid&in_ready, register the operands, clear the accumulator and counter, go to MUL.
  - MUL: exactly MAN_W+1 cycles. In cycle i, if mb[i]=1, add ma<<i into the 2(MAN_W+1)-bit accumulator. Leave MUL when counter = MAN_W.
  - NORM: one cycle. Normalize, compute the exponent, apply special cases, register result.
  - DONE: out_valid=1, result held stable. If out_ready=1, go to IDLE. If out_ready=0, stay with result unchanged.
- Latency: the accept edge is edge 0. out_valid rises at edge LAT = 26 by default. This holds for all inputs, including special cases.
- No overlap: in_ready=0 from the accept edge until the edge on which out_valid&out_ready completes. in_ready is 1 again the following cycle.
- Significands: ma = {1,fa}, mb = {1,fb}. Product P is 2*MAN_W+2 bits.
- Normalization:
  - If P[MSB]=1: frac = P[MSB-1 -: MAN_W], exponent +1.
  - Else: frac = P[MSB-2 -: MAN_W].
  - Rounding is truncation (round toward zero).
- Exponent:
  - e = ea + eb - BIAS (+1 if normalized), computed in EXP_W+2-bit signed arithmetic.
  - e ≥ 2^EXP_W-1 gives ±Inf.
  - e ≤ 0 gives ±0. Subnormal results are flushed.
- Sign: sa XOR sb, for every non-NaN result.
- Special-case priority, highest first:
  1. Either input NaN, or Inf×zero/subnormal: canonical qNaN, which is {0, all-ones exp, 1, zeros}. Default 32'h7FC00000.
  2. Either input Inf: signed Inf.
  3. Either input zero or subnormal (exp=0): signed zero. Subnormal inputs are treated as zero.
  4. Otherwise the normal path.
- Operand inputs are ignored when in_ready=0.

Decomposition:
- Package fp_pkg holds:
  - EXP_W and MAN_W defaults, plus derived W and BIAS.
  - State enum {IDLE, MUL, NORM, DONE}.
  - Functions is_nan, is_inf, is_zero_or_sub.
  - QNAN constant.
- One sub-module, mant_mul_seq, holds the shift-add significand multiplier:
  - start/busy/done handshake.
  - Accumulator and bit counter.
  - done pulses in the last MUL cycle.
- The top level holds the FSM, exponent/sign logic, normalization, special cases and the output register.

Test Plan:
- Basic product: a=3FC00000 (1.5), b=40000000 (2.0), accepted at edge 0 → out_valid rises at edge 26, result=40400000. in_ready=0 during edges 0–26.
- Sign and truncation:
  - BF800000 × 3F800000 → BF800000.
  - 3F800001 × 3F800001 → 3F800002 (truncated, not rounded).
- Overflow/underflow:
  - 7F000000 × 7F000000 → 7F800000.
  - 00800000 × 00800000 → 00000000.
  - 80800000 × 00800000 → 80000000.
- Specials, each still with latency 26:
  - 7F800000 × 00000000 → 7FC00000.
  - 7FC00001 × 3F800000 → 7FC00000.
  - FF800000 × 40000000 → FF800000.
  - 00000001 × 3F800000 → 00000000.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → result and out_valid stable, in_ready=0. in_valid pulses during this window are ignored. Raise out_ready → in_ready=1 next cycle, and a back-to-back second operation completes correctly.
- Reset mid-operation: drop rst_n at edge 10 after accept → out_valid=0 and result=0 immediately (asynchronous). After release, in_ready=1 at the next edge and no stale result ever appears. A fresh 1.5×2.0 then gives 40400000.
